// File: rtl/imem_responder.sv
// imem_responder: memory end of the instruction-fetch interface.
// Accepts one fetch per cycle. Each fetch returns its 32-bit word, byte address and fault
// flag exactly LATENCY cycles after the accepting edge, in request order.
// A load port fills the word array. A flush discards every fetch still in flight.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   imem_req/imem_addr  fetch request and byte address
//   imem_flush          drop all in-flight fetches
//   imem_ready          combinational accept qualifier
//   imem_rvalid/rdata/raddr/rerr  response (registered)
//   load_we/addr/wdata  program-load write port
//   busy                any pipeline stage holds a valid fetch
module imem_responder #(
    parameter int unsigned  DEPTH_WORDS = 1024,
    parameter int unsigned  LATENCY     = 1,
    parameter logic [31:0]  ERR_FILL    = 32'h0000_0013,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          imem_req,
    input  logic [31:0]   imem_addr,
    input  logic          imem_flush,
    output logic          imem_ready,
    output logic          imem_rvalid,
    output logic [31:0]   imem_rdata,
    output logic [31:0]   imem_raddr,
    output logic          imem_rerr,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_wdata,
    output logic          busy
);

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic        err;
    } stage_t;

    logic [31:0]        mem [DEPTH_WORDS];
    stage_t             st [LATENCY];
    logic [LATENCY-1:0] st_vld;
    logic               accept;
    logic               addr_err;
    stage_t             fetch;

    // Program-load write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_wdata;
        end
    end

    assign imem_ready = !rst && !load_we && !imem_flush;
    assign accept     = imem_req && imem_ready;

    // Full-width range compare: addresses beyond the array fault instead of wrapping.
    assign addr_err = (imem_addr[1:0] != 2'b00) ||
                      ({2'b00, imem_addr[31:2]} >= 32'(DEPTH_WORDS));

    always_comb begin
        fetch      = '0;
        fetch.addr = imem_addr;
        fetch.err  = addr_err;
        fetch.data = addr_err ? ERR_FILL : mem[imem_addr[AW+1:2]];
    end

    // Fetch pipeline; payload registers only move with a valid fetch so the output
    // stage holds its last response while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_vld <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                st[i] <= '0;
            end
        end else begin
            st_vld[0] <= accept;
            if (accept) begin
                st[0] <= fetch;
            end
            for (int i = 1; i < int'(LATENCY); i++) begin
                st_vld[i] <= st_vld[i-1] && !imem_flush;
                if (st_vld[i-1] && !imem_flush) begin
                    st[i] <= st[i-1];
                end
            end
        end
    end

    assign imem_rvalid = st_vld[LATENCY-1];
    assign imem_rdata  = st[LATENCY-1].data;
    assign imem_raddr  = st[LATENCY-1].addr;
    assign imem_rerr   = st[LATENCY-1].err;
    assign busy        = |st_vld;

endmodule
